program_sequencer: RTL and testbench

Parametrised next-generation program counter for the single-cycle CPU. It sits between the control unit and the instruction ROM address port. It generates the fetch address with sequential increment, PC-relative branch, absolute jump, and subroutine call/return through an optional hardware return-address stack (RAS). A HALT state freezes fetch until the control unit resumes it.

---
 rtl/program_sequencer_pkg.sv | 21 ++
 rtl/program_sequencer_return_addr_stack.sv | 52 +++++
 rtl/program_sequencer.sv | 140 ++++++++++++++
 tb/tb_program_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// program_sequencer shared types and constants.
// State and next-PC select encodings used by the sequencer.
package program_sequencer_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    BRANCH,
    JUMP,
    CALL,
    RET
  } sel_t;

endpackage

// File: rtl/program_sequencer_return_addr_stack.sv
// Circular return-address stack; a push on a full stack
// overwrites the oldest entry and the count saturates.
module return_addr_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_m1;
  logic [CW-1:0] cnt_q;

  assign ptr_m1 = ptr_q - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign count  = cnt_q;

  // Storage needs no reset; slot at ptr_q is the oldest when full.
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr_q] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PW'(1);
      if (!full)
        cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_m1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address generator with branch/jump/call/ret and HALT.
// PROGRAM_SEQUENCER_RAS_EN enables the return-address stack.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable_increment,
  input  logic                       branch_en,
  input  logic [ADDR_W-1:0]          branch_off,
  input  logic                       jump_en,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic                       call_en,
  input  logic                       ret_en,
  input  logic                       halt_req,
  input  logic                       resume,
  output logic [ADDR_W-1:0]          pc,
  output logic                       halted,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  state_t            state_q;
  sel_t              sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              advance;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign advance = (state_q == RUN) && enable_increment && !halt_req;
  assign pc      = pc_q;
  assign halted  = (state_q == HALT);

  // Priority arbitration: ret > call > jump > branch > increment.
  always_comb begin
    sel = HOLD;
    if (advance) begin
`ifdef PROGRAM_SEQUENCER_RAS_EN
      if (ret_en)
        sel = RET;
      else if (call_en)
        sel = CALL;
      else if (jump_en)
`else
      if (call_en || jump_en)
`endif
        sel = JUMP;
      else if (branch_en)
        sel = BRANCH;
      else
        sel = INC;
    end
  end

  // Next fetch address; arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    pc_nxt = pc_q;
    case (sel)
      INC:        pc_nxt = pc_inc;
      BRANCH:     pc_nxt = pc_q + branch_off;
      JUMP, CALL: pc_nxt = jump_addr;
      RET:        pc_nxt = ras_empty ? pc_inc : ras_top;
      default:    pc_nxt = pc_q;
    endcase
  end

  // PC register and RUN/HALT state machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
    end else begin
      pc_q <= pc_nxt;
      unique case (state_q)
        RUN:     if (halt_req) state_q <= HALT;
        HALT:    if (resume && !halt_req) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PROGRAM_SEQUENCER_RAS_EN
  logic          ras_full;
  logic [CW-1:0] ras_cnt;
  logic          ovf_q;
  logic          unf_q;

  return_addr_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (sel == CALL),
    .pop       (sel == RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .count     (ras_cnt)
  );

  // Sticky stack error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (sel == CALL && ras_full)
        ovf_q <= 1'b1;
      if (sel == RET && ras_empty)
        unf_q <= 1'b1;
    end
  end

  assign ras_count     = ras_cnt;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  logic unused_ret;

  assign unused_ret    = ret_en;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed test for program_sequencer.
// Covers both stack-enabled and stack-less builds.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable_increment;
  logic       branch_en;
  logic [7:0] branch_off;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       call_en;
  logic       ret_en;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] ras_count;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_chk = 0;
  int n_err = 0;

  program_sequencer #(
    .ADDR_W     (8),
    .RESET_ADDR (8'h10),
    .RAS_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_increment (enable_increment),
    .branch_en        (branch_en),
    .branch_off       (branch_off),
    .jump_en          (jump_en),
    .jump_addr        (jump_addr),
    .call_en          (call_en),
    .ret_en           (ret_en),
    .halt_req         (halt_req),
    .resume           (resume),
    .pc               (pc),
    .halted           (halted),
    .ras_count        (ras_count),
    .ras_overflow     (ras_overflow),
    .ras_underflow    (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    branch_en = 0; jump_en = 0; call_en = 0;
    ret_en = 0; halt_req = 0; resume = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [7:0] a);
    idle();
    jump_en = 1; jump_addr = a;
    step();
    idle();
  endtask

  task automatic do_call(input logic [7:0] a);
    idle();
    call_en = 1; jump_addr = a;
    step();
    idle();
  endtask

  task automatic do_ret();
    idle();
    ret_en = 1;
    step();
    idle();
  endtask

  logic [7:0] rets [4];

  initial begin
    reset_n = 0;
    enable_increment = 0;
    branch_off = 0;
    jump_addr = 0;
    idle();
    #12;
    check("rst_pc", pc, 8'h10);
    check("rst_halted", halted, 0);
    check("rst_cnt", ras_count, 0);
    @(negedge clk);
    reset_n = 1;
    enable_increment = 1;

    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("inc%0d", i), pc, 8'h10 + i);
    end

    do_jump(8'hFF);
    check("jmp_ff", pc, 8'hFF);
    step();
    check("wrap", pc, 8'h00);

    do_jump(8'h05);
    branch_en = 1; branch_off = 8'hFE;
    step();
    idle();
    check("br_back", pc, 8'h03);

    branch_en = 1; branch_off = 8'h7F;
    jump_en = 0;
    step();
    idle();
    check("br_fwd", pc, 8'h82);

    enable_increment = 0;
    jump_en = 1; jump_addr = 8'h44;
    step(); step();
    idle();
    check("en_low", pc, 8'h82);
    enable_increment = 1;

    do_jump(8'h20);
    do_call(8'h80);
    check("call_pc", pc, 8'h80);
`ifdef PROGRAM_SEQUENCER_RAS_EN
    check("call_cnt", ras_count, 1);
    do_ret();
    check("ret_pc", pc, 8'h21);
    check("ret_cnt", ras_count, 0);

    do_jump(8'h40);
    for (int i = 0; i < 5; i++)
      do_call(8'h50 + 8'(i * 16));
    check("nest_pc", pc, 8'h90);
    check("nest_cnt", ras_count, 4);
    check("ovf", ras_overflow, 1);
    check("unf0", ras_underflow, 0);
    rets = '{8'h81, 8'h71, 8'h61, 8'h51};
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check($sformatf("nret%0d", i), pc, rets[i]);
    end
    check("nret_cnt", ras_count, 0);
    do_ret();
    check("unf_pc", pc, 8'h52);
    check("unf", ras_underflow, 1);
    check("ovf_sticky", ras_overflow, 1);
`else
    check("call_cnt", ras_count, 0);
    do_ret();
    check("ret_ign", pc, 8'h81);
    for (int i = 0; i < 5; i++)
      do_call(8'h50 + 8'(i * 16));
    check("nest_pc", pc, 8'h90);
    check("nest_cnt", ras_count, 0);
    check("ovf", ras_overflow, 0);
    do_ret();
    check("unf", ras_underflow, 0);
    check("ret_ign2", pc, 8'h91);
`endif

    do_jump(8'h30);
    halt_req = 1; jump_en = 1; jump_addr = 8'h77;
    step();
    check("halt_pc", pc, 8'h30);
    check("halted", halted, 1);
    halt_req = 0;
    step();
    check("halt_hold", pc, 8'h30);
    check("halt_stay", halted, 1);
    jump_en = 0;
    resume = 1;
    step();
    resume = 0;
    check("resume_h", halted, 0);
    check("resume_pc", pc, 8'h30);
    step();
    check("post_res", pc, 8'h31);

    do_call(8'hA0);
    call_en = 1; jump_addr = 8'hB0;
    @(posedge clk);
    #1;
    reset_n = 0;
    #1;
    check("arst_pc", pc, 8'h10);
    check("arst_cnt", ras_count, 0);
    check("arst_ovf", ras_overflow, 0);
    check("arst_unf", ras_underflow, 0);
    check("arst_halt", halted, 0);
    idle();
    @(negedge clk);
    reset_n = 1;
    step();
    check("post_rst", pc, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
